fetch_unit: RTL

Instruction-fetch front end for the single-cycle/pipelined MIPS datapath. Owns the program counter and drives the address port of the synchronous instruction ROM. Pairs each word returning one cycle later with its PC and a valid flag for the decode stage. Handles decode stalls, branch/jump redirects, misaligned targets and an optional branch-delay slot.

---
 rtl/fetch_if.sv | 25 ++
 rtl/fetch_unit.sv | 97 +++++++++
 2 files changed

// File: rtl/fetch_if.sv
// Fetch-unit bundle: decode-side handshake plus the instruction ROM address/data port.
// The master is the fetch unit; the slave is the decode stage / ROM side.
interface fetch_if;
  logic        stall;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4_out;
  logic        valid_out;
  logic        misalign_err;
  logic [31:0] fetch_count;

  modport master (
    input  stall, redirect_en, redirect_pc, imem_data,
    output imem_addr, instr_out, pc_out, pc_plus4_out, valid_out, misalign_err, fetch_count
  );

  modport slave (
    output stall, redirect_en, redirect_pc, imem_data,
    input  imem_addr, instr_out, pc_out, pc_plus4_out, valid_out, misalign_err, fetch_count
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, drives the synchronous ROM address and pairs each
// returning word with its PC. Optional branch-delay slot enabled by FETCH_DELAY_SLOT_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic    clock,
  input logic    reset,
  fetch_if.master bus
);

  logic [31:0] pc_q;
  logic [31:0] fetch_pc_q;
  logic        fetch_valid_q;
  logic        err_q;
  logic [31:0] count_q;

  logic [31:0] tgt;
  logic [31:0] jump_pc;
  logic [31:0] fetch_addr;
  logic        hold;
  logic        do_jump;
  logic        consume;

  assign tgt = {bus.redirect_pc[31:2], 2'b00};

`ifdef FETCH_DELAY_SLOT_EN
  logic [31:0] pending_q;
  logic        pending_valid_q;

  // Redirect never overrides the current cycle; the slot word is fetched first.
  assign hold    = bus.stall && fetch_valid_q;
  assign do_jump = !hold && pending_valid_q;
  assign jump_pc = pending_q;

  // Capture the target (even while stalled) and release it on the first non-HOLD cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending_q       <= 32'h0;
      pending_valid_q <= 1'b0;
    end else if (bus.redirect_en) begin
      pending_q       <= tgt;
      pending_valid_q <= 1'b1;
    end else if (do_jump) begin
      pending_valid_q <= 1'b0;
    end
  end
`else
  // Immediate redirect wins over stall; the word currently presented counts as consumed.
  assign hold    = bus.stall && fetch_valid_q && !bus.redirect_en;
  assign do_jump = bus.redirect_en;
  assign jump_pc = tgt;
`endif

  assign consume = fetch_valid_q && !hold;

  // ROM address: redirect target, re-read of the held word, or the sequential PC.
  always_comb begin
    fetch_addr = pc_q;
    if (reset) begin
      fetch_addr = RESET_PC;
    end else if (do_jump) begin
      fetch_addr = jump_pc;
    end else if (hold) begin
      fetch_addr = fetch_pc_q;
    end
  end

  // PC, in-flight address, valid flag, misalignment pulse and delivery counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      fetch_pc_q    <= RESET_PC;
      fetch_valid_q <= 1'b0;
      err_q         <= 1'b0;
      count_q       <= 32'h0;
    end else begin
      if (!hold) begin
        fetch_pc_q    <= fetch_addr;
        pc_q          <= fetch_addr + 32'd4;
        fetch_valid_q <= 1'b1;
      end
      err_q <= bus.redirect_en && (bus.redirect_pc[1:0] != 2'b00);
      if (consume) begin
        count_q <= count_q + 32'd1;
      end
    end
  end

  assign bus.imem_addr    = fetch_addr;
  assign bus.instr_out    = bus.imem_data;
  assign bus.pc_out       = fetch_pc_q;
  assign bus.pc_plus4_out = fetch_pc_q + 32'd4;
  assign bus.valid_out    = fetch_valid_q;
  assign bus.misalign_err = err_q;
  assign bus.fetch_count  = count_q;

endmodule
